transceiver_tx: RTL and testbench

- Outbound half of the board's serial move link; pairs with the inbound move receiver on the same line.
- Accepts a packed 22-bit move or a colour announcement.
- Serialises it into an ASCII line ("e2e4\n", "e7e8q\n", "-W\n", "-B\n").
- Hands bytes one at a time to the UART transmitter using a strobe/done handshake.

---
 rtl/transceiver_tx_pkg.sv | 61 ++++++
 rtl/transceiver_tx_if.sv | 31 +++
 rtl/transceiver_tx_move_to_ascii.sv | 43 ++++
 rtl/transceiver_tx.sv | 142 ++++++++++++++
 tb/tb_transceiver_tx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/transceiver_tx_pkg.sv
// ---------------------------------------------------------------------------
// transceiver_tx_pkg
// Shared definitions for the serial move link: ASCII constants, transmitter
// state encoding, packed-move field offsets (also used by the receiver side)
// and promotion codes.
// No ports (package).
// ---------------------------------------------------------------------------
package transceiver_tx_pkg;

    localparam int MAX_LEN = 6;
    localparam int LEN_W   = 3;

    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_DASH   = 8'h2D;
    localparam logic [7:0] ASC_W      = 8'h57;
    localparam logic [7:0] ASC_B      = 8'h42;
    localparam logic [7:0] ASC_A      = 8'h61;
    localparam logic [7:0] ASC_1      = 8'h31;
    localparam logic [7:0] ASC_Q      = 8'h71;
    localparam logic [7:0] ASC_R      = 8'h72;
    localparam logic [7:0] ASC_BISHOP = 8'h62;
    localparam logic [7:0] ASC_N      = 8'h6E;

    // Packed move layout: each field is 3 bits wide, LSB position given.
    localparam int MV_FIELD_W     = 3;
    localparam int MV_SRC_FILE    = 19;
    localparam int MV_SRC_RANK    = 16;
    localparam int MV_DST_FILE    = 13;
    localparam int MV_DST_RANK    = 10;
    localparam int MV_PROMO       = 7;
    localparam int MV_IGNORED_MSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } tx_state_e;

    typedef enum logic [2:0] {
        PROMO_NONE = 3'd0,
        PROMO_Q    = 3'd1,
        PROMO_R    = 3'd2,
        PROMO_B    = 3'd3,
        PROMO_N    = 3'd4
    } promo_e;

    // Returns the promotion character, or 8'h00 when the code means "none"
    // (0 and the unused codes 5-7).
    function automatic logic [7:0] promo_char(input logic [2:0] code);
        logic [7:0] c;
        case (code)
            PROMO_Q: c = ASC_Q;
            PROMO_R: c = ASC_R;
            PROMO_B: c = ASC_BISHOP;
            PROMO_N: c = ASC_N;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/transceiver_tx_if.sv
// ---------------------------------------------------------------------------
// transceiver_tx_if
// Request and UART handshake bundle of the move transmitter.
//   start_move/move_in    : one-cycle move send request + packed move
//   start_color/color_in  : one-cycle colour-line request + colour bit
//   tx_done               : UART finished shifting the current byte
//   tx_dv/tx_byte         : one-cycle strobe + byte for the UART
//   busy/end_send         : frame in progress / frame completed pulse
// master = requester/UART side, slave = transmitter.
// ---------------------------------------------------------------------------
interface transceiver_tx_if;
    logic        start_move;
    logic [21:0] move_in;
    logic        start_color;
    logic        color_in;
    logic        tx_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        end_send;

    modport master (
        output start_move, move_in, start_color, color_in, tx_done,
        input  tx_dv, tx_byte, busy, end_send
    );

    modport slave (
        input  start_move, move_in, start_color, color_in, tx_done,
        output tx_dv, tx_byte, busy, end_send
    );
endinterface

// File: rtl/transceiver_tx_move_to_ascii.sv
// ---------------------------------------------------------------------------
// transceiver_tx_move_to_ascii
// Combinational encoder: packed move -> ASCII frame bytes plus frame length.
//   i_move  : packed 22-bit move
//   o_bytes : frame bytes, byte 0 sent first; unused tail bytes are zero
//   o_len   : 5 (plain move) or 6 (promotion)
// MAX_LEN must be at least 6.
// ---------------------------------------------------------------------------
module transceiver_tx_move_to_ascii
    import transceiver_tx_pkg::*;
#(
    parameter int         MAX_LEN = transceiver_tx_pkg::MAX_LEN,
    parameter int         LEN_W   = transceiver_tx_pkg::LEN_W,
    parameter logic [7:0] LF      = transceiver_tx_pkg::ASC_LF
) (
    input  logic [21:0]              i_move,
    output logic [MAX_LEN-1:0][7:0]  o_bytes,
    output logic [LEN_W-1:0]         o_len
);

    logic [7:0] w_promo;
    logic       w_unused_bits;

    assign w_promo       = promo_char(i_move[MV_PROMO +: MV_FIELD_W]);
    assign w_unused_bits = ^i_move[MV_IGNORED_MSB:0];

    always_comb begin
        o_bytes    = '0;
        o_bytes[0] = ASC_A + {5'd0, i_move[MV_SRC_FILE +: MV_FIELD_W]};
        o_bytes[1] = ASC_1 + {5'd0, i_move[MV_SRC_RANK +: MV_FIELD_W]};
        o_bytes[2] = ASC_A + {5'd0, i_move[MV_DST_FILE +: MV_FIELD_W]};
        o_bytes[3] = ASC_1 + {5'd0, i_move[MV_DST_RANK +: MV_FIELD_W]};
        if (w_promo != 8'h00) begin
            o_bytes[4] = w_promo;
            o_bytes[5] = LF;
            o_len      = LEN_W'(6);
        end else begin
            o_bytes[4] = LF;
            o_len      = LEN_W'(5);
        end
    end

endmodule

// File: rtl/transceiver_tx.sv
// ---------------------------------------------------------------------------
// transceiver_tx
// Outbound half of the serial move link. Latches a move or colour line into
// a byte buffer and feeds it to the UART one byte per tx_dv/tx_done round.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : transceiver_tx_if.slave (requests in, UART handshake out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame; a start latches the frame and strobes byte 0
// WAIT    | byte in flight at the UART; tx_done advances or finishes
// DONE    | end_send high, busy low; returns to IDLE next cycle
// ---------------------------------------------------------------------------
module transceiver_tx
    import transceiver_tx_pkg::*;
#(
    parameter int         MAX_LEN = transceiver_tx_pkg::MAX_LEN,
    parameter logic [7:0] LF      = transceiver_tx_pkg::ASC_LF
) (
    input  logic              clock,
    input  logic              reset,
    transceiver_tx_if.slave   bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    tx_state_e                r_state,    w_state_nxt;
    logic [MAX_LEN-1:0][7:0]  r_buf,      w_buf_nxt;
    logic [LEN_W-1:0]         r_len,      w_len_nxt;
    logic [LEN_W-1:0]         r_index,    w_index_nxt;
    logic                     r_tx_dv,    w_tx_dv_nxt;
    logic [7:0]               r_tx_byte,  w_tx_byte_nxt;
    logic                     r_busy,     w_busy_nxt;
    logic                     r_end_send, w_end_send_nxt;

    logic [MAX_LEN-1:0][7:0]  w_move_bytes;
    logic [LEN_W-1:0]         w_move_len;
    logic [MAX_LEN-1:0][7:0]  w_color_bytes;

    transceiver_tx_move_to_ascii #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .LF      (LF)
    ) u_move_to_ascii (
        .i_move  (bus.move_in),
        .o_bytes (w_move_bytes),
        .o_len   (w_move_len)
    );

    always_comb begin
        w_color_bytes    = '0;
        w_color_bytes[0] = ASC_DASH;
        w_color_bytes[1] = bus.color_in ? ASC_B : ASC_W;
        w_color_bytes[2] = LF;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_len      <= '0;
            r_index    <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_busy     <= 1'b0;
            r_end_send <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_len      <= w_len_nxt;
            r_index    <= w_index_nxt;
            r_tx_dv    <= w_tx_dv_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_busy     <= w_busy_nxt;
            r_end_send <= w_end_send_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_len_nxt      = r_len;
        w_index_nxt    = r_index;
        w_tx_dv_nxt    = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_busy_nxt     = r_busy;
        w_end_send_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_move || bus.start_color) begin
                    // A move request takes priority over a simultaneous colour request.
                    if (bus.start_move) begin
                        w_buf_nxt = w_move_bytes;
                        w_len_nxt = w_move_len;
                    end else begin
                        w_buf_nxt = w_color_bytes;
                        w_len_nxt = LEN_W'(3);
                    end
                    w_index_nxt   = '0;
                    w_tx_byte_nxt = w_buf_nxt[0];
                    w_tx_dv_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.tx_done) begin
                    if (r_index < r_len - LEN_W'(1)) begin
                        w_index_nxt   = r_index + LEN_W'(1);
                        w_tx_byte_nxt = r_buf[r_index + LEN_W'(1)];
                        w_tx_dv_nxt   = 1'b1;
                    end else begin
                        // DONE's outputs are loaded on entry so end_send
                        // follows the final tx_done by exactly one cycle.
                        w_end_send_nxt = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_index_nxt    = '0;
                        w_state_nxt    = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.tx_dv    = r_tx_dv;
    assign bus.tx_byte  = r_tx_byte;
    assign bus.busy     = r_busy;
    assign bus.end_send = r_end_send;

endmodule

// File: tb/tb_transceiver_tx.sv
// ---------------------------------------------------------------------------
// tb_transceiver_tx
// Self-checking bench for transceiver_tx: directed vector table, randomized
// frames against a byte-list reference model, and hand-written reset/idle
// sequences.
// ---------------------------------------------------------------------------
module tb_transceiver_tx;

    localparam int BUDGET = 2000;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    transceiver_tx_if bus_if ();

    transceiver_tx u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        smove;
        logic [21:0] mv;
        logic        scol;
        logic        col;
        int          gap;
        int          mid_at;
        int          n;
        logic [7:0]  b [6];
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: frame as a list of characters built directly from the
    // encoding rules.
    task automatic model_frame(input logic is_move, input logic [21:0] mv,
                               input logic col, output logic [7:0] q[$]);
        logic [7:0] promo_tab [8];
        promo_tab = '{8'h00, 8'h71, 8'h72, 8'h62, 8'h6E, 8'h00, 8'h00, 8'h00};
        q = {};
        if (is_move) begin
            q.push_back(8'h61 + 8'(mv[21:19]));
            q.push_back(8'h31 + 8'(mv[18:16]));
            q.push_back(8'h61 + 8'(mv[15:13]));
            q.push_back(8'h31 + 8'(mv[12:10]));
            if (promo_tab[mv[9:7]] != 8'h00) q.push_back(promo_tab[mv[9:7]]);
        end else begin
            q.push_back(8'h2D);
            q.push_back(col ? 8'h42 : 8'h57);
        end
        q.push_back(8'h0A);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check($sformatf("%s_len", tag), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
            else
                check($sformatf("%s_byte%0d_missing", tag, i), 32'hFFFF_FFFF, 32'(exp[i]));
        end
    endtask

    // Issues a start at the current negedge and acts as the UART: each tx_dv
    // is answered with a one-cycle tx_done 'gap' cycles later. Optionally
    // pulses start_move/start_color at cycle 'mid_at' while the frame runs.
    task automatic run_frame(input string tag, input logic smove, input logic [21:0] mv,
                             input logic scol, input logic col, input int gap,
                             input int mid_at, output logic [7:0] got[$]);
        int         cnt;
        int         done_cyc;
        int         end_cyc;
        int         lat_err;
        int         stable_err;
        int         busy_err;
        logic       saw_end;
        logic [7:0] last;
        got        = {};
        cnt        = 0;
        done_cyc   = -100;
        end_cyc    = -1;
        lat_err    = 0;
        stable_err = 0;
        busy_err   = 0;
        saw_end    = 1'b0;
        last       = 8'h00;

        bus_if.start_move  = smove;
        bus_if.move_in     = mv;
        bus_if.start_color = scol;
        bus_if.color_in    = col;
        @(negedge clock);
        bus_if.start_move  = 1'b0;
        bus_if.start_color = 1'b0;
        bus_if.move_in     = 22'($urandom);
        bus_if.color_in    = 1'($urandom);
        check({tag, "_first_dv"}, 32'(bus_if.tx_dv), 32'd1);
        check({tag, "_busy_rise"}, 32'(bus_if.busy), 32'd1);

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (bus_if.end_send) begin
                saw_end = 1'b1;
                end_cyc = cyc;
                break;
            end
            if (bus_if.tx_dv) begin
                if (cyc != 0 && cyc != done_cyc + 1) lat_err++;
                got.push_back(bus_if.tx_byte);
                last = bus_if.tx_byte;
            end else if (bus_if.tx_byte !== last) begin
                stable_err++;
            end
            if (!bus_if.busy) busy_err++;

            bus_if.tx_done     = 1'b0;
            bus_if.start_move  = (cyc == mid_at);
            bus_if.start_color = (cyc == mid_at + 1);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus_if.tx_done = 1'b1;
                    done_cyc       = cyc;
                end
            end
            if (bus_if.tx_dv) cnt = gap;
            @(negedge clock);
        end
        bus_if.tx_done     = 1'b0;
        bus_if.start_move  = 1'b0;
        bus_if.start_color = 1'b0;

        check({tag, "_end_seen"}, 32'(saw_end), 32'd1);
        check({tag, "_end_latency"}, 32'(end_cyc), 32'(done_cyc + 1));
        check({tag, "_busy_at_end"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_dv_latency_errs"}, 32'(lat_err), 32'd0);
        check({tag, "_byte_stable_errs"}, 32'(stable_err), 32'd0);
        check({tag, "_busy_drop_errs"}, 32'(busy_err), 32'd0);
        @(negedge clock);
        check({tag, "_end_one_cycle"}, 32'(bus_if.end_send), 32'd0);
        check({tag, "_idle_no_dv"}, 32'(bus_if.tx_dv), 32'd0);
        @(negedge clock);
        check({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] got [$];
        logic [7:0] exp [$];
        logic       smove;
        logic       scol;
        logic       col;
        logic [21:0] mv;

        n_checks = 0;
        n_errors = 0;

        //           smove mv                                          scol  col   gap  mid  n   bytes
        vecs[0] = '{1'b1, {3'd4,3'd1,3'd4,3'd3,3'd0,7'd0},   1'b0, 1'b0, 10, -1, 5,
                    '{8'h65,8'h32,8'h65,8'h34,8'h0A,8'h00}};
        vecs[1] = '{1'b1, {3'd4,3'd6,3'd4,3'd7,3'd1,7'd0},   1'b0, 1'b0, 10, -1, 6,
                    '{8'h65,8'h37,8'h65,8'h38,8'h71,8'h0A}};
        vecs[2] = '{1'b1, {3'd4,3'd6,3'd4,3'd7,3'd6,7'd0},   1'b0, 1'b0, 3,  -1, 5,
                    '{8'h65,8'h37,8'h65,8'h38,8'h0A,8'h00}};
        vecs[3] = '{1'b0, 22'd0,                              1'b1, 1'b0, 4,  -1, 3,
                    '{8'h2D,8'h57,8'h0A,8'h00,8'h00,8'h00}};
        vecs[4] = '{1'b0, 22'd0,                              1'b1, 1'b1, 1,  -1, 3,
                    '{8'h2D,8'h42,8'h0A,8'h00,8'h00,8'h00}};
        vecs[5] = '{1'b1, {3'd4,3'd1,3'd4,3'd3,3'd0,7'd0},   1'b1, 1'b1, 2,  -1, 5,
                    '{8'h65,8'h32,8'h65,8'h34,8'h0A,8'h00}};
        vecs[6] = '{1'b1, {3'd4,3'd6,3'd4,3'd7,3'd1,7'd0},   1'b0, 1'b0, 10, 15, 6,
                    '{8'h65,8'h37,8'h65,8'h38,8'h71,8'h0A}};
        vecs[7] = '{1'b1, {3'd0,3'd0,3'd7,3'd7,3'd4,7'h55},  1'b0, 1'b0, 100, -1, 6,
                    '{8'h61,8'h31,8'h68,8'h38,8'h6E,8'h0A}};

        bus_if.start_move  = 1'b0;
        bus_if.move_in     = '0;
        bus_if.start_color = 1'b0;
        bus_if.color_in    = 1'b0;
        bus_if.tx_done     = 1'b0;
        reset              = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_tx_dv", 32'(bus_if.tx_dv), 32'd0);
        check("rst_tx_byte", 32'(bus_if.tx_byte), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_end_send", 32'(bus_if.end_send), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // tx_done while idle must not start anything.
        bus_if.tx_done = 1'b1;
        @(negedge clock);
        bus_if.tx_done = 1'b0;
        check("idle_done_dv", 32'(bus_if.tx_dv), 32'd0);
        check("idle_done_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clock);
        check("idle_done_end", 32'(bus_if.end_send), 32'd0);

        for (int v = 0; v < 8; v++) begin
            exp = {};
            for (int i = 0; i < vecs[v].n; i++) exp.push_back(vecs[v].b[i]);
            run_frame($sformatf("vec%0d", v), vecs[v].smove, vecs[v].mv, vecs[v].scol,
                      vecs[v].col, vecs[v].gap, vecs[v].mid_at, got);
            compare_frame($sformatf("vec%0d", v), got, exp);
        end

        // Reset after the 2nd tx_done of an e2e4 frame.
        bus_if.start_move = 1'b1;
        bus_if.move_in    = {3'd4,3'd1,3'd4,3'd3,3'd0,7'd0};
        @(negedge clock);
        bus_if.start_move = 1'b0;
        check("rstmid_dv0", 32'(bus_if.tx_dv), 32'd1);
        bus_if.tx_done = 1'b1;
        @(negedge clock);
        bus_if.tx_done = 1'b0;
        check("rstmid_dv1", 32'(bus_if.tx_dv), 32'd1);
        check("rstmid_byte1", 32'(bus_if.tx_byte), 32'h32);
        bus_if.tx_done = 1'b1;
        @(negedge clock);
        bus_if.tx_done = 1'b0;
        check("rstmid_dv2", 32'(bus_if.tx_dv), 32'd1);
        reset = 1'b0;
        #1;
        check("rstmid_async_dv", 32'(bus_if.tx_dv), 32'd0);
        check("rstmid_async_busy", 32'(bus_if.busy), 32'd0);
        begin
            int end_seen;
            end_seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (bus_if.end_send) end_seen++;
            end
            reset = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (bus_if.end_send || bus_if.tx_dv) end_seen++;
            end
            check("rstmid_no_end_send", 32'(end_seen), 32'd0);
        end
        model_frame(1'b1, {3'd4,3'd1,3'd4,3'd3,3'd0,7'd0}, 1'b0, exp);
        run_frame("post_rst", 1'b1, {3'd4,3'd1,3'd4,3'd3,3'd0,7'd0}, 1'b0, 1'b0, 2, -1, got);
        compare_frame("post_rst", got, exp);

        // Randomized frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            smove = ($urandom_range(3) != 0);
            scol  = smove ? 1'($urandom_range(1)) : 1'b1;
            col   = 1'($urandom_range(1));
            mv    = 22'($urandom);
            model_frame(smove, mv, col, exp);
            run_frame($sformatf("rnd%0d", r), smove, mv, scol, col,
                      int'($urandom_range(6, 1)),
                      ($urandom_range(1) != 0) ? int'($urandom_range(20, 1)) : -1, got);
            compare_frame($sformatf("rnd%0d", r), got, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
